mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 32-bit 4-to-1 mux datapath (inputs a/b/c/d, 2-bit sel). It accepts up to four valid/ready requesters, decides which input owns the mux each cycle, and drives `sel`. It captures the selected word into a one-entry output register with a valid/ready handshake toward the consumer. Ownership may be held for a bounded burst of consecutive beats before rotating.

---
 rtl/mux_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin burst arbiter driving a 4:1 mux into a one-entry output register
module mux_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req_valid,
   output logic [3:0]       req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_id
);

   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   logic [0:0]       st_q, st_d;
   logic [1:0]       owner_q, owner_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [1:0]       out_id_q;

   logic             load_en;
   logic             any_req;
   logic             cont;
   logic             grant;
   logic [1:0]       gnt_id;
   logic [1:0]       winner;
   logic [1:0]       idx;
   logic             found;
   logic [WIDTH-1:0] sel_data;

   assign load_en = !out_valid_q || out_ready;
   assign any_req = |req_valid;
   // The current owner keeps the mux only while it still has data and budget left
   assign cont    = (st_q == ST_OWN) && req_valid[owner_q] && (cnt_q < BURST_C);

   // Rotating priority scan starting just after the last owner; old owner comes last
   always_comb begin
      winner = owner_q;
      found  = 1'b0;
      idx    = owner_q;
      for (int k = 1; k <= 4; k++) begin
         idx = owner_q + 2'(k);
         if (!found && req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Grant decision and next-state; release re-arbitrates in the same cycle (no bubble)
   always_comb begin
      grant   = 1'b0;
      gnt_id  = owner_q;
      st_d    = st_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (load_en) begin
         if (cont) begin
            grant = 1'b1;
            cnt_d = cnt_q + CW'(1);
         end else if (any_req) begin
            grant   = 1'b1;
            gnt_id  = winner;
            owner_d = winner;
            cnt_d   = CW'(1);
            st_d    = (BURST > 1) ? ST_OWN : ST_IDLE;
         end else begin
            st_d = ST_IDLE;
         end
      end
   end

   // Handshake outputs are forced quiet while reset is held
   always_comb begin
      req_ready = 4'b0000;
      sel       = 2'd0;
      if (rst_n) begin
         sel = grant ? gnt_id : owner_q;
         if (grant) begin
            req_ready[gnt_id] = 1'b1;
         end
      end
   end

   // Data mux feeding only the output register
   always_comb begin
      sel_data = a;
      case (gnt_id)
         2'd0:    sel_data = a;
         2'd1:    sel_data = b;
         2'd2:    sel_data = c;
         default: sel_data = d;
      endcase
   end

   // Arbiter state and output register; a new capture overrides a pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q        <= ST_IDLE;
         owner_q     <= 2'd3;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= 2'd0;
      end else begin
         st_q    <= st_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_id_q    <= gnt_id;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] a, b, c, d;
   logic [1:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_id;

   int errors = 0;
   int checks = 0;

   mux_rr_arbiter #(.WIDTH(32), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .a(a), .b(b), .c(c), .d(d), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = 4'b0000;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] word_of(input logic [1:0] id);
      case (id)
         2'd0:    return 32'hAAAA0000;
         2'd1:    return 32'hBBBB0001;
         2'd2:    return 32'hCCCC0002;
         default: return 32'hDDDD0003;
      endcase
   endfunction

   task automatic set_words();
      a = 32'hAAAA0000; b = 32'hBBBB0001; c = 32'hCCCC0002; d = 32'hDDDD0003;
   endtask

   task automatic test_reset();
      set_words();
      rst_n = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel got=%0d exp=0", sel); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id got=%0d exp=0", out_id); end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_first_sel got=%0d exp=0", sel); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_cap_valid got=%b exp=1", out_valid); end
      checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_cap_id got=%0d exp=0", out_id); end
      checks++; if (out_data !== 32'hAAAA0000) begin errors++; $display("FAIL rst_cap_data got=%h exp=AAAA0000", out_data); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_ids [17];
      exp_ids = '{2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd1,2'd2,2'd2,2'd2,2'd2,2'd3,2'd3,2'd3,2'd3,2'd0};
      set_words();
      apply_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 17; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_id !== exp_ids[i]) begin errors++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, out_id, exp_ids[i]); end
         checks++; if (out_data !== word_of(exp_ids[i])) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, out_data, word_of(exp_ids[i])); end
      end
   endtask

   task automatic test_single();
      apply_reset();
      c = 32'hCAFEF00D;
      req_valid = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=0100", i, req_ready); end
         tick();
         checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL single_id[%0d] got=%0d exp=2", i, out_id); end
         checks++; if (out_data !== 32'hCAFEF00D) begin errors++; $display("FAIL single_data[%0d] got=%h exp=CAFEF00D", i, out_data); end
      end
      req_valid = 4'b0000;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'hCAFEF00D) begin errors++; $display("FAIL single_drain_data got=%h exp=CAFEF00D", out_data); end
   endtask

   task automatic test_backpressure();
      set_words();
      apply_reset();
      req_valid = 4'b0011;
      a = 32'h0000_0001;
      tick();
      a = 32'h0000_0002;
      tick();
      checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL bp_pre_data got=%h exp=2", out_data); end
      a = 32'h0000_0099;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready); end
         checks++; if (sel !== 2'd0) begin errors++; $display("FAIL bp_sel[%0d] got=%0d exp=0", i, sel); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== 32'h2 || out_id !== 2'd0) begin errors++; $display("FAIL bp_hold[%0d] got=%h/%0d exp=2/0", i, out_data, out_id); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume3 got=%b exp=0001", req_ready); end
      tick();
      checks++; if (out_data !== 32'h99) begin errors++; $display("FAIL bp_resume_data got=%h exp=99", out_data); end
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume4 got=%b exp=0001", req_ready); end
      tick();
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_rotate got=%b exp=0010", req_ready); end
      tick();
      checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL bp_rotate_id got=%0d exp=1", out_id); end
   endtask

   task automatic test_early_release();
      logic [3:0] exp_rdy [11];
      exp_rdy = '{4'b0001,4'b0001,4'b0010,4'b0010,4'b0010,4'b0010,
                  4'b1000,4'b1000,4'b1000,4'b1000,4'b0010};
      set_words();
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         req_valid = (i < 2) ? 4'b1011 : 4'b1010;
         #1;
         checks++; if (req_ready !== exp_rdy[i]) begin errors++; $display("FAIL early_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy[i]); end
         tick();
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [3:0] exp_rdy [5];
      exp_rdy = '{4'b0100,4'b0100,4'b0100,4'b0100,4'b1000};
      set_words();
      apply_reset();
      req_valid = 4'b0100;
      tick();
      tick();
      checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL midrst_pre_id got=%0d exp=2", out_id); end
      rst_n = 1'b0;
      req_valid = 4'b1100;
      #1;
      checks++; if (req_ready !== 4'b0000 || sel !== 2'd0) begin errors++; $display("FAIL midrst_quiet got=%b/%0d exp=0000/0", req_ready, sel); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (req_ready !== exp_rdy[i]) begin errors++; $display("FAIL midrst_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy[i]); end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 4'b0000; out_ready = 1'b1;
      a = '0; b = '0; c = '0; d = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_early_release();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
